// File: rtl/psum_accum_relu_q4_x2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accum_relu_q4_x2_pkg
//  Brief    : Shared constants and helpers for the int4 conv output stage
//             (partial-sum width, int4 limits, default requant shift).
//  Revision : 1.0  initial release
// ============================================================================
package psum_accum_relu_q4_x2_pkg;

    // Width of a signed per-group partial sum coming out of the conv kernel
    localparam int PSUM_W     = 15;
    // Unsigned int4 output range
    localparam int Q4_W       = 4;
    localparam int Q4_MAX     = 15;
    // Default requantisation settings
    localparam int DEF_SHIFT  = 4;
    localparam int DEF_GROUPS = 4;
    localparam int DEF_ACC_W  = 21;

    // Width of the group counter; a single-group build still needs one bit
    function automatic int grp_width(input int groups);
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

    // Rounding constant added before an arithmetic right shift (half-up)
    function automatic int round_const(input int shift);
        return 1 << (shift - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_accum_relu_q4_x2_relu_round_sat_q4.sv
`default_nettype none
// ============================================================================
//  Module   : relu_round_sat_q4
//  Brief    : Combinational ReLU, round-half-up right shift and unsigned
//             saturation of one accumulated sum, plus a clip indicator.
//  Revision : 1.0  initial release
// ============================================================================
module relu_round_sat_q4
    import psum_accum_relu_q4_x2_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = Q4_W
)(
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] q,
    output logic             clip
);

    // One extra bit so the rounding add cannot wrap for the largest positive sum
    localparam logic [ACC_W:0] c_round = (ACC_W+1)'(round_const(SHIFT));
    localparam logic [ACC_W:0] c_max   = (ACC_W+1)'((1 << OUT_W) - 1);

    logic             w_pos;
    logic [ACC_W:0]   w_rounded;
    logic [ACC_W:0]   w_shifted;
    logic             w_over;

    // Only strictly positive sums pass the ReLU; the magnitude path below is
    // evaluated unsigned and its result is discarded when the sum is <= 0.
    assign w_pos     = ~sum[ACC_W-1] & (|sum);
    assign w_rounded = {1'b0, sum} + c_round;
    assign w_shifted = w_rounded >> SHIFT;
    assign w_over    = (w_shifted > c_max);

    assign clip = w_pos & w_over;

    // Select zero, the clamped maximum code, or the rounded value
    always_comb begin
        q = '0;
        if (w_pos) begin
            if (w_over) begin
                q = c_max[OUT_W-1:0];
            end else begin
                q = w_shifted[OUT_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_accum_relu_q4_x2.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accum_relu_q4_x2
//  Brief    : Accumulates 2-channel signed partial sums over GROUPS input
//             groups, then applies ReLU / round / int4 saturation and emits
//             one quantised pixel per completed group set.
//  Revision : 1.0  initial release
// ============================================================================
module psum_accum_relu_q4_x2
    import psum_accum_relu_q4_x2_pkg::*;
#(
    parameter int IN_W   = PSUM_W,
    parameter int GROUPS = DEF_GROUPS,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OUT_W  = Q4_W
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [IN_W-1:0]               psum_ch1,
    input  logic [IN_W-1:0]               psum_ch2,
    input  logic                          sat_clr,
    output logic                          out_valid,
    output logic [OUT_W-1:0]              out_ch1,
    output logic [OUT_W-1:0]              out_ch2,
    output logic                          sat_flag,
    output logic [grp_width(GROUPS)-1:0]  grp_idx
);

    localparam int              GRP_W      = grp_width(GROUPS);
    localparam logic [GRP_W-1:0] c_last_grp = GRP_W'(GROUPS - 1);

    logic [GRP_W-1:0]        r_grp;
    logic [GRP_W-1:0]        w_eff_grp;
    logic [GRP_W-1:0]        w_grp_nxt;
    logic                    w_first;
    logic                    w_last;

    logic signed [ACC_W-1:0] w_ext_ch1;
    logic signed [ACC_W-1:0] w_ext_ch2;
    logic signed [ACC_W-1:0] w_sum_ch1;
    logic signed [ACC_W-1:0] w_sum_ch2;
    logic signed [ACC_W-1:0] r_acc_ch1;
    logic signed [ACC_W-1:0] r_acc_ch2;

    logic                    r_s1_valid;
    logic signed [ACC_W-1:0] r_s1_sum_ch1;
    logic signed [ACC_W-1:0] r_s1_sum_ch2;

    logic [OUT_W-1:0]        w_q_ch1;
    logic [OUT_W-1:0]        w_q_ch2;
    logic                    w_clip_ch1;
    logic                    w_clip_ch2;

    logic                    r_out_valid;
    logic [OUT_W-1:0]        r_out_ch1;
    logic [OUT_W-1:0]        r_out_ch2;
    logic                    r_sat_flag;

    // A start-of-frame beat forces group 0, which drops any partial pixel
    assign w_eff_grp = in_sof ? '0 : r_grp;
    assign w_first   = (w_eff_grp == '0);
    assign w_last    = (w_eff_grp == c_last_grp);
    assign w_grp_nxt = w_last ? '0 : w_eff_grp + GRP_W'(1);

    assign w_ext_ch1 = ACC_W'($signed(psum_ch1));
    assign w_ext_ch2 = ACC_W'($signed(psum_ch2));
    assign w_sum_ch1 = w_first ? w_ext_ch1 : r_acc_ch1 + w_ext_ch1;
    assign w_sum_ch2 = w_first ? w_ext_ch2 : r_acc_ch2 + w_ext_ch2;

    // Group counter and running accumulators advance only on valid beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grp     <= '0;
            r_acc_ch1 <= '0;
            r_acc_ch2 <= '0;
        end else if (in_valid) begin
            r_grp     <= w_grp_nxt;
            r_acc_ch1 <= w_sum_ch1;
            r_acc_ch2 <= w_sum_ch2;
        end
    end

    // Stage 1: capture the completed pixel sum on its last-group beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sum_ch1 <= '0;
            r_s1_sum_ch2 <= '0;
        end else begin
            r_s1_valid <= in_valid & w_last;
            if (in_valid && w_last) begin
                r_s1_sum_ch1 <= w_sum_ch1;
                r_s1_sum_ch2 <= w_sum_ch2;
            end
        end
    end

    relu_round_sat_q4 #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_q_ch1 (
        .sum  (r_s1_sum_ch1),
        .q    (w_q_ch1),
        .clip (w_clip_ch1)
    );

    relu_round_sat_q4 #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_q_ch2 (
        .sum  (r_s1_sum_ch2),
        .q    (w_q_ch2),
        .clip (w_clip_ch2)
    );

    // Stage 2: register quantised pixel; values hold between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ch1   <= '0;
            r_out_ch2   <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_ch1 <= w_q_ch1;
                r_out_ch2 <= w_q_ch2;
            end
        end
    end

    // Sticky saturation flag; a new clip event outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
        end else if (r_s1_valid && (w_clip_ch1 || w_clip_ch2)) begin
            r_sat_flag <= 1'b1;
        end else if (sat_clr) begin
            r_sat_flag <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch1   = r_out_ch1;
    assign out_ch2   = r_out_ch2;
    assign sat_flag  = r_sat_flag;
    assign grp_idx   = r_grp;

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_relu_q4_x2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accum_relu_q4_x2
//  Brief    : Directed, table-driven bench for psum_accum_relu_q4_x2
//             (GROUPS=4, SHIFT=4, OUT_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_psum_accum_relu_q4_x2;

    localparam int IN_W   = 15;
    localparam int GROUPS = 4;
    localparam int ACC_W  = 21;
    localparam int SHIFT  = 4;
    localparam int OUT_W  = 4;
    localparam int NVEC   = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic [IN_W-1:0]   psum_ch1 = '0;
    logic [IN_W-1:0]   psum_ch2 = '0;
    logic              sat_clr = 1'b0;
    logic              out_valid;
    logic [OUT_W-1:0]  out_ch1;
    logic [OUT_W-1:0]  out_ch2;
    logic              sat_flag;
    logic [1:0]        grp_idx;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int v;    int sof;  int c1;  int c2;  int clr;
        int eov;  int eo1;  int eo2; int esat; int egrp;
    } vec_t;

    vec_t tbl [NVEC];

    psum_accum_relu_q4_x2 #(
        .IN_W   (IN_W),
        .GROUPS (GROUPS),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .psum_ch1  (psum_ch1),
        .psum_ch2  (psum_ch2),
        .sat_clr   (sat_clr),
        .out_valid (out_valid),
        .out_ch1   (out_ch1),
        .out_ch2   (out_ch2),
        .sat_flag  (sat_flag),
        .grp_idx   (grp_idx)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int v, input int sof, input int c1, input int c2,
                                input int clr, input int eov, input int eo1, input int eo2,
                                input int esat, input int egrp);
        vec_t r;
        r.v = v; r.sof = sof; r.c1 = c1; r.c2 = c2; r.clr = clr;
        r.eov = eov; r.eo1 = eo1; r.eo2 = eo2; r.esat = esat; r.egrp = egrp;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input int v, input int sof, input int c1, input int c2, input int clr);
        in_valid = v[0];
        in_sof   = sof[0];
        psum_ch1 = IN_W'(c1);
        psum_ch2 = IN_W'(c2);
        sat_clr  = clr[0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int eov, input int eo1, input int eo2,
                           input int esat, input int egrp);
        chk({tag, "_ov"},  int'(out_valid), eov);
        chk({tag, "_ch1"}, int'(out_ch1),   eo1);
        chk({tag, "_ch2"}, int'(out_ch2),   eo2);
        chk({tag, "_sat"}, int'(sat_flag),  esat);
        chk({tag, "_grp"}, int'(grp_idx),   egrp);
    endtask

    initial begin
        int ov_cnt;
        int bub [8];

        // v sof  c1   c2  clr | ov  o1  o2 sat grp
        // Basic pixel: ch1 sum 160 -> 10, ch2 sum -20 -> 0
        tbl[0]  = mk(1,0, 100, -5, 0,  0,  0, 0, 0, 1);
        tbl[1]  = mk(1,0,  50, -5, 0,  0,  0, 0, 0, 2);
        tbl[2]  = mk(1,0, -20, -5, 0,  0,  0, 0, 0, 3);
        tbl[3]  = mk(1,0,  30, -5, 0,  0,  0, 0, 0, 0);
        tbl[4]  = mk(0,0,   0,  0, 0,  1, 10, 0, 0, 0);
        tbl[5]  = mk(0,0,   0,  0, 0,  0, 10, 0, 0, 0);
        // Rounding: 23 -> 1, 24 -> 2, -1 -> 0 (bubble inside second pixel)
        tbl[6]  = mk(1,0,  23,  0, 0,  0, 10, 0, 0, 1);
        tbl[7]  = mk(1,0,   0,  0, 0,  0, 10, 0, 0, 2);
        tbl[8]  = mk(1,0,   0,  0, 0,  0, 10, 0, 0, 3);
        tbl[9]  = mk(1,0,   0,  0, 0,  0, 10, 0, 0, 0);
        tbl[10] = mk(1,0,  24,  0, 0,  1,  1, 0, 0, 1);
        tbl[11] = mk(0,0,   0,  0, 0,  0,  1, 0, 0, 1);
        tbl[12] = mk(1,0,   0,  0, 0,  0,  1, 0, 0, 2);
        tbl[13] = mk(1,0,   0,  0, 0,  0,  1, 0, 0, 3);
        tbl[14] = mk(1,0,   0,  0, 0,  0,  1, 0, 0, 0);
        tbl[15] = mk(1,0,  -1,  0, 0,  1,  2, 0, 0, 1);
        tbl[16] = mk(1,0,   0,  0, 0,  0,  2, 0, 0, 2);
        tbl[17] = mk(1,0,   0,  0, 0,  0,  2, 0, 0, 3);
        tbl[18] = mk(1,0,   0,  0, 0,  0,  2, 0, 0, 0);
        tbl[19] = mk(0,0,   0,  0, 0,  1,  0, 0, 0, 0);
        // Saturation: 400 -> 25 -> clamp 15, sticky, then clear
        tbl[20] = mk(1,0, 200,  0, 0,  0,  0, 0, 0, 1);
        tbl[21] = mk(1,0, 200,  0, 0,  0,  0, 0, 0, 2);
        tbl[22] = mk(1,0,   0,  0, 0,  0,  0, 0, 0, 3);
        tbl[23] = mk(1,0,   0,  0, 0,  0,  0, 0, 0, 0);
        tbl[24] = mk(0,0,   0,  0, 0,  1, 15, 0, 1, 0);
        tbl[25] = mk(0,0,   0,  0, 0,  0, 15, 0, 1, 0);
        tbl[26] = mk(0,0,   0,  0, 1,  0, 15, 0, 0, 0);
        // Resync: two abandoned beats, then sof + 3 beats of 16 -> 4; ch2 16 -> 1
        tbl[27] = mk(1,0, 100, 50, 0,  0, 15, 0, 0, 1);
        tbl[28] = mk(1,0, 100, 50, 0,  0, 15, 0, 0, 2);
        tbl[29] = mk(1,1,  16,  4, 0,  0, 15, 0, 0, 1);
        tbl[30] = mk(1,0,  16,  4, 0,  0, 15, 0, 0, 2);
        tbl[31] = mk(1,0,  16,  4, 0,  0, 15, 0, 0, 3);
        tbl[32] = mk(1,0,  16,  4, 0,  0, 15, 0, 0, 0);
        tbl[33] = mk(0,0,   0,  0, 0,  1,  4, 1, 0, 0);
        // ch2 clip 300 -> 15 with sat_clr in the same cycle: set wins
        tbl[34] = mk(1,0,   0,300, 0,  0,  4, 1, 0, 1);
        tbl[35] = mk(1,0,   0,  0, 0,  0,  4, 1, 0, 2);
        tbl[36] = mk(1,0,   0,  0, 0,  0,  4, 1, 0, 3);
        tbl[37] = mk(1,0,   0,  0, 0,  0,  4, 1, 0, 0);
        tbl[38] = mk(0,0,   0,  0, 1,  1,  0,15, 1, 0);
        tbl[39] = mk(0,0,   0,  0, 1,  0,  0,15, 0, 0);

        // Reset state
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].v, tbl[i].sof, tbl[i].c1, tbl[i].c2, tbl[i].clr);
            chk_all($sformatf("row%0d", i), tbl[i].eov, tbl[i].eo1, tbl[i].eo2,
                    tbl[i].esat, tbl[i].egrp);
        end

        // Streaming: 8 back-to-back beats, ch1 40 each -> 10, ch2 8 each -> 2
        ov_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) step(1, 0, 40, 8, 0);
            else       step(0, 0, 0, 0, 0);
            if (out_valid) begin
                ov_cnt++;
                chk($sformatf("stream_a%0d_ch1", i), int'(out_ch1), 10);
                chk($sformatf("stream_a%0d_ch2", i), int'(out_ch2), 2);
            end
        end
        chk("stream_a_count", ov_cnt, 2);

        // Streaming with single-cycle bubbles: ch1 50 each -> 13, ch2 -8 each -> 0
        bub = '{0, 1, 0, 0, 1, 0, 1, 0};
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bub[i] != 0) begin
                step(0, 0, 0, 0, 0);
                if (out_valid) begin
                    ov_cnt++;
                    chk($sformatf("stream_b%0d_bch1", i), int'(out_ch1), 13);
                    chk($sformatf("stream_b%0d_bch2", i), int'(out_ch2), 0);
                end
            end
            step(1, 0, 50, -8, 0);
            if (out_valid) begin
                ov_cnt++;
                chk($sformatf("stream_b%0d_ch1", i), int'(out_ch1), 13);
                chk($sformatf("stream_b%0d_ch2", i), int'(out_ch2), 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            if (out_valid) begin
                ov_cnt++;
                chk($sformatf("stream_bt%0d_ch1", i), int'(out_ch1), 13);
                chk($sformatf("stream_bt%0d_ch2", i), int'(out_ch2), 0);
            end
        end
        chk("stream_b_count", ov_cnt, 2);

        // Reset after the third beat of a pixel
        step(1, 1, 10, 10, 0);
        step(1, 0, 10, 10, 0);
        step(1, 0, 10, 10, 0);
        chk("pre_rst_grp", int'(grp_idx), 3);
        rst_n = 1'b0;
        step(1, 0, 10, 10, 0);
        chk_all("rst_mid", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("rst_mid_quiet%0d", i), int'(out_valid), 0);
        end

        // Reset while the last beat is in flight in stage 1
        step(1, 0, 100, 100, 0);
        step(1, 0, 100, 100, 0);
        step(1, 0, 100, 100, 0);
        step(1, 0, 100, 100, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        chk_all("rst_flight", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("rst_flight_quiet%0d", i), int'(out_valid), 0);
        end

        // Next full pixel after reset: ch1 64 -> 4, ch2 100 -> 6
        step(1, 0, 16, 100, 0);
        step(1, 0, 16, 0, 0);
        step(1, 0, 16, 0, 0);
        step(1, 0, 16, 0, 0);
        chk("post_rst_ov_early", int'(out_valid), 0);
        step(0, 0, 0, 0, 0);
        chk_all("post_rst", 1, 4, 6, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
